audio_adc_rx: RTL

- Receive side of the codec digital audio interface: deserialises ADCDAT from the codec running as I2S master (24-bit, I2S format, MS=1).
- Oversamples codec-driven BCLK/ADCLRC in the sys_clk domain and assembles signed left/right 24-bit sample pairs.
- Delivers pairs to downstream sound processing over a valid/ready handshake.
- Sits beside the DAC transmit path and reuses the same codec configuration.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/audio_sync_edge.sv | 29 ++
 rtl/audio_adc_rx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-interface definitions: sample width, I2S framing delay,
// channel and receive-FSM state encodings.
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 24;
  localparam int I2S_DELAY_BITS     = 1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/audio_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus one-cycle rise and
// fall event strobes in the sys_clk domain.
module audio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/audio_adc_rx.sv
// I2S receive path: oversamples codec BCLK/ADCLRC/ADCDAT and delivers signed
// left/right pairs on a valid/ready handshake. Optional peak meters under
// AUDIO_ADC_RX_PEAK_EN.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first frame-clock edge
//   SKIP  | new slot started, consuming the I2S delay bit(s)
//   SHIFT | capturing sample bits MSB first
//   HOLD  | slot complete, ignoring bits until the next frame-clock edge
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    bclk,
  input  logic                    adclrc,
  input  logic                    adcdat,
  output logic [SAMPLE_WIDTH-1:0] data_left,
  output logic [SAMPLE_WIDTH-1:0] data_right,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    frame_err,
`ifdef AUDIO_ADC_RX_PEAK_EN
  output logic [SAMPLE_WIDTH-2:0] peak_left,
  output logic [SAMPLE_WIDTH-2:0] peak_right,
`endif
  input  logic                    clr_status
);

  localparam int CNT_W  = $clog2(SAMPLE_WIDTH + 1);
  localparam int SKIP_W = (I2S_DELAY_BITS > 1) ? $clog2(I2S_DELAY_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SAMPLE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(I2S_DELAY_BITS - 1);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);

  logic bclk_rise;
  logic bclk_fall_unused;

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk_i   (sys_clk),
    .rst_n_i (reset),
    .d_i     (bclk),
    .rise_o  (bclk_rise),
    .fall_o  (bclk_fall_unused)
  );

  logic [SYNC_STAGES-1:0] lrc_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   lrc_s;
  logic                   dat_s;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      lrc_sync_q <= '0;
      dat_sync_q <= '0;
    end else begin
      lrc_sync_q <= {lrc_sync_q[SYNC_STAGES-2:0], adclrc};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], adcdat};
    end
  end

  assign lrc_s = lrc_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  rx_state_t               state_q, state_d;
  channel_t                ch_q, ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SKIP_W-1:0]       skip_q, skip_d;
  logic [SAMPLE_WIDTH-2:0] shreg_q, shreg_d;
  logic                    lrc_prev_q, lrc_prev_d;
  logic                    primed_q, primed_d;
  logic                    ferr_d;
  logic                    lrc_edge;
  logic                    lat_left, lat_right;
  logic [SAMPLE_WIDTH-1:0] word;

  // The first rise after reset only records the frame-clock level, so a
  // reset released mid-slot never looks like a frame boundary.
  assign lrc_edge = bclk_rise & primed_q & (lrc_s != lrc_prev_q);
  assign word     = {shreg_q, dat_s};

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    shreg_d    = shreg_q;
    lrc_prev_d = lrc_prev_q;
    primed_d   = primed_q;
    ferr_d     = 1'b0;
    lat_left   = 1'b0;
    lat_right  = 1'b0;

    if (bclk_rise) begin
      lrc_prev_d = lrc_s;
      primed_d   = 1'b1;
    end

    if (lrc_edge) begin
      ferr_d  = (state_q == SKIP) || (state_q == SHIFT);
      state_d = SKIP;
      ch_d    = lrc_s ? CH_RIGHT : CH_LEFT;
      skip_d  = SKIP_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SKIP: begin
          if (skip_q == '0) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end else if (bclk_rise) begin
            skip_d = skip_q - SKIP_ONE;
          end
        end
        SHIFT: begin
          if (bclk_rise) begin
            shreg_d = word[SAMPLE_WIDTH-2:0];
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == LAST_BIT) begin
              state_d   = HOLD;
              lat_left  = (ch_q == CH_LEFT);
              lat_right = (ch_q == CH_RIGHT);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ch_q       <= CH_LEFT;
      cnt_q      <= '0;
      skip_q     <= '0;
      shreg_q    <= '0;
      lrc_prev_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      shreg_q    <= shreg_d;
      lrc_prev_q <= lrc_prev_d;
      primed_q   <= primed_d;
    end
  end

  logic [SAMPLE_WIDTH-1:0] left_hold_q, right_hold_q;
  logic                    left_have_q;
  logic                    pair_pend_q;

  // A right channel only completes a pair if a left arrived since the last one.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_have_q  <= 1'b0;
      pair_pend_q  <= 1'b0;
    end else begin
      pair_pend_q <= lat_right & left_have_q;
      if (lat_left) begin
        left_hold_q <= word;
        left_have_q <= 1'b1;
      end
      if (lat_right) begin
        left_have_q <= 1'b0;
        if (left_have_q) right_hold_q <= word;
      end
    end
  end

  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q;
  logic [SAMPLE_WIDTH-1:0] data_left_q, data_right_q;
  logic                    load;

  assign load = pair_pend_q & (~out_valid_q | out_ready);

  always_comb begin
    out_valid_d = load | (out_valid_q & ~out_ready);
    overrun_d   = (pair_pend_q & ~load) | (overrun_q & ~clr_status);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      data_left_q  <= '0;
      data_right_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= ferr_d;
      if (load) begin
        data_left_q  <= left_hold_q;
        data_right_q <= right_hold_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign data_left  = data_left_q;
  assign data_right = data_right_q;

`ifdef AUDIO_ADC_RX_PEAK_EN
  localparam logic [SAMPLE_WIDTH-2:0] MAG_ONE = (SAMPLE_WIDTH-1)'(1);

  // Most-negative input saturates to the largest positive magnitude.
  function automatic logic [SAMPLE_WIDTH-2:0] magnitude(input logic [SAMPLE_WIDTH-1:0] s);
    logic [SAMPLE_WIDTH-2:0] m;
    if (!s[SAMPLE_WIDTH-1])               m = s[SAMPLE_WIDTH-2:0];
    else if (s[SAMPLE_WIDTH-2:0] == '0)   m = '1;
    else                                  m = ~s[SAMPLE_WIDTH-2:0] + MAG_ONE;
    return m;
  endfunction

  logic [SAMPLE_WIDTH-2:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [SAMPLE_WIDTH-2:0] mag_l, mag_r;

  always_comb begin
    mag_l    = magnitude(left_hold_q);
    mag_r    = magnitude(right_hold_q);
    peak_l_d = clr_status ? '0 : peak_l_q;
    peak_r_d = clr_status ? '0 : peak_r_q;
    if (load && (mag_l > peak_l_d)) peak_l_d = mag_l;
    if (load && (mag_r > peak_r_d)) peak_r_d = mag_r;
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_left  = peak_l_q;
  assign peak_right = peak_r_q;
`endif

endmodule
